// File: rtl/wallace_mul_seq.sv
// wallace_mul_seq: multi-cycle unsigned multiplier built around a single 4x4
// Wallace-tree core. One nibble pair is multiplied per cycle. Each partial
// product is shifted into position and accumulated.
// Optional build macro: MUL_ZERO_BYPASS_EN. When it is defined, a zero operand
// skips the BUSY sequence and goes straight to DONE with a zero result.

// 4x4 unsigned multiplier: partial-product rows, two 3:2 CSA levels, final add
module WallaceTree_Mul (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] s1, c1, s2, c2;

    assign r0 = b_i[0] ? {4'b0000, a_i}        : 8'h00;
    assign r1 = b_i[1] ? {3'b000, a_i, 1'b0}   : 8'h00;
    assign r2 = b_i[2] ? {2'b00, a_i, 2'b00}   : 8'h00;
    assign r3 = b_i[3] ? {1'b0, a_i, 3'b000}   : 8'h00;

    // First CSA level reduces three rows to sum and carry vectors.
    assign s1 = r0 ^ r1 ^ r2;
    assign c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;

    // Second CSA level folds in the last row.
    assign s2 = s1 ^ c1 ^ r3;
    assign c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;

    // The product is at most 225, so 8 bits of the final add are exact.
    assign p_o = s2 + c2;
endmodule

module wallace_mul_seq #(
    parameter int unsigned NIB_A = 2,
    parameter int unsigned NIB_B = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4*NIB_A-1:0]           A,
    input  logic [4*NIB_B-1:0]           B,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*(NIB_A+NIB_B)-1:0]   Result,
    output logic                         busy
);
    localparam int unsigned AW = 4 * NIB_A;
    localparam int unsigned BW = 4 * NIB_B;
    localparam int unsigned RW = 4 * (NIB_A + NIB_B);
    localparam int unsigned IW = 3;
    localparam logic [IW-1:0] LAST_I = IW'(NIB_A - 1);
    localparam logic [IW-1:0] LAST_J = IW'(NIB_B - 1);

    // Reject operand sizes the 3-bit nibble indices cannot address.
    if (NIB_A < 1 || NIB_A > 8 || NIB_B < 1 || NIB_B > 8) begin : g_bad_param
        $error("wallace_mul_seq: NIB_A and NIB_B must be in 1..8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic          in_ready_q, out_valid_q, busy_q;

    logic [3:0]    a_nib, b_nib;
    logic [7:0]    pp;
    logic [5:0]    sh;

    // Select the current nibble pair and its bit offset 4*(i+j).
    assign a_nib = 4'(a_q >> {i_q, 2'b00});
    assign b_nib = 4'(b_q >> {j_q, 2'b00});
    assign sh    = {1'b0, i_q, 2'b00} + {1'b0, j_q, 2'b00};

    WallaceTree_Mul u_mul (
        .a_i (a_nib),
        .b_i (b_nib),
        .p_o (pp)
    );

    // Next-state, operand capture and accumulation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = A;
                    b_d   = B;
                    acc_d = '0;
                    i_d   = '0;
                    j_d   = '0;
`ifdef MUL_ZERO_BYPASS_EN
                    if (A == '0 || B == '0) state_d = S_DONE;
                    else                    state_d = S_BUSY;
`else
                    state_d = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                acc_d = acc_q + (RW'(pp) << sh);
                if (j_q == LAST_J) begin
                    j_d = '0;
                    if (i_q == LAST_I) state_d = S_DONE;
                    else               i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath registers and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d == S_BUSY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Result    = acc_q;
endmodule
